mem_arbiter: RTL and testbench

Shares the single byte-wide RAM port between the instruction-fetch path and the load/store path. It serialises 32-bit instruction fetches and 1/2/4-byte data accesses into byte transactions and reassembles the results little-endian. It sits between the fetch unit, which feeds the instruction queue, and the load/store unit on one side, and the external RAM bus on the other. It supports pipeline pause (`rdy`) and fetch flush (`clr_i`).

---
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter: serialises 32-bit instruction fetches and 1/2/4-byte
// loads/stores into byte transactions and reassembles read data little-endian.
module mem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clr_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_done_o,
   output logic [31:0]       if_data_o,
   input  logic              ls_req_i,
   input  logic              ls_we_i,
   input  logic [2:0]        ls_len_i,
   input  logic [ADDR_W-1:0] ls_addr_i,
   input  logic [31:0]       ls_wdata_i,
   output logic              ls_done_o,
   output logic [31:0]       ls_rdata_o,
   output logic [ADDR_W-1:0] ram_a_o,
   output logic [7:0]        ram_dout_o,
   output logic              ram_wr_o,
   input  logic [7:0]        ram_din_i
);

   typedef enum logic [2:0] {
      IDLE,
      IF_RD,
      LS_RD,
      LS_WR,
      DONE
   } state_t;

   state_t      state;
   logic [2:0]  cnt;
   logic [2:0]  len;
   logic [ADDR_W-1:0] base;
   logic [31:0] wdata;
   logic [31:0] assembly;
   logic [31:0] merged;
   logic [7:0]  wr_byte;

   // RAM read data lags the address by one cycle, so the byte landing while
   // cnt=k belongs to index k-1.
   always_comb begin
      merged = assembly;
      case (cnt)
         3'd1:    merged[7:0]   = ram_din_i;
         3'd2:    merged[15:8]  = ram_din_i;
         3'd3:    merged[23:16] = ram_din_i;
         3'd4:    merged[31:24] = ram_din_i;
         default: merged = assembly;
      endcase
   end

   always_comb begin
      wr_byte = 8'h00;
      case (cnt[1:0])
         2'd0: wr_byte = wdata[7:0];
         2'd1: wr_byte = wdata[15:8];
         2'd2: wr_byte = wdata[23:16];
         2'd3: wr_byte = wdata[31:24];
         default: wr_byte = 8'h00;
      endcase
   end

   // The write strobe is gated by rdy so a paused byte is never written twice.
   assign ram_a_o    = base + ADDR_W'(cnt);
   assign ram_wr_o   = (state == LS_WR) && rdy;
   assign ram_dout_o = (state == LS_WR) ? wr_byte : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 3'd0;
         len        <= 3'd0;
         base       <= '0;
         wdata      <= 32'h0;
         assembly   <= 32'h0;
         if_done_o  <= 1'b0;
         ls_done_o  <= 1'b0;
         if_data_o  <= 32'h0;
         ls_rdata_o <= 32'h0;
      end else if (rdy) begin
         if_done_o <= 1'b0;
         ls_done_o <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= 3'd0;
               if (ls_req_i) begin
                  len      <= ls_len_i;
                  base     <= ls_addr_i;
                  assembly <= 32'h0;
                  if (ls_we_i) begin
                     wdata <= ls_wdata_i;
                     state <= LS_WR;
                  end else begin
                     state <= LS_RD;
                  end
               end else if (if_req_i && !clr_i) begin
                  len      <= 3'd4;
                  base     <= if_addr_i;
                  assembly <= 32'h0;
                  state    <= IF_RD;
               end
            end
            IF_RD, LS_RD: begin
               if (state == IF_RD && clr_i) begin
                  state <= IDLE;
                  cnt   <= 3'd0;
               end else begin
                  assembly <= merged;
                  if (cnt == len) begin
                     state <= DONE;
                     if (state == IF_RD) begin
                        if_done_o <= 1'b1;
                        if_data_o <= merged;
                     end else begin
                        ls_done_o  <= 1'b1;
                        ls_rdata_o <= merged;
                     end
                  end else begin
                     cnt <= cnt + 3'd1;
                  end
               end
            end
            LS_WR: begin
               if (cnt == len - 3'd1) begin
                  state     <= DONE;
                  ls_done_o <= 1'b1;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               cnt   <= 3'd0;
            end
            default: begin
               state <= IDLE;
               cnt   <= 3'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural byte RAM, shadow-memory reference model and a
// scoreboard monitor that checks every completion against queued expectations.
module tb_mem_arbiter;

   localparam int TIMEOUT = 300;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        clr_i = 1'b0;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = 32'h0;
   logic        if_done_o;
   logic [31:0] if_data_o;
   logic        ls_req_i = 1'b0;
   logic        ls_we_i = 1'b0;
   logic [2:0]  ls_len_i = 3'd1;
   logic [31:0] ls_addr_i = 32'h0;
   logic [31:0] ls_wdata_i = 32'h0;
   logic        ls_done_o;
   logic [31:0] ls_rdata_o;
   logic [31:0] ram_a_o;
   logic [7:0]  ram_dout_o;
   logic        ram_wr_o;
   logic [7:0]  ram_din_i = 8'h00;

   int vectors = 0;
   int miscompares = 0;
   int strobes = 0;
   int wrWhilePaused = 0;

   bit [7:0] ram[bit [31:0]];
   bit [7:0] shadow[bit [31:0]];
   logic [31:0] ifExp[$];
   logic [32:0] lsExp[$];

   mem_arbiter #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clr_i(clr_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o), .if_data_o(if_data_o),
      .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_len_i(ls_len_i), .ls_addr_i(ls_addr_i),
      .ls_wdata_i(ls_wdata_i), .ls_done_o(ls_done_o), .ls_rdata_o(ls_rdata_o),
      .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o), .ram_din_i(ram_din_i)
   );

   always #5 clk = ~clk;

   function automatic bit [7:0] initByte(input bit [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic bit [7:0] ramRead(input bit [31:0] a);
      return ram.exists(a) ? ram[a] : initByte(a);
   endfunction

   function automatic bit [7:0] shadowRead(input bit [31:0] a);
      return shadow.exists(a) ? shadow[a] : initByte(a);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // External RAM: clock-enabled by rdy, read data one cycle after the address.
   always @(posedge clk) begin
      if (rdy) begin
         if (ram_wr_o) ram[ram_a_o] = ram_dout_o;
         ram_din_i <= ramRead(ram_a_o);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (ram_wr_o) strobes++;
         if (ram_wr_o && !rdy) wrWhilePaused++;
      end
   end

   // Scoreboard monitor: every accepted completion pops the oldest expectation.
   always @(negedge clk) begin : monitor
      logic [31:0] e;
      logic [32:0] le;
      if (!rst && rdy) begin
         if (if_done_o) begin
            if (ifExp.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL if_unexpected: if_done_o with data %h, expected no fetch completion", if_data_o);
            end else begin
               e = ifExp.pop_front();
               checkOutput("if_data", if_data_o, e);
            end
         end
         if (ls_done_o) begin
            if (lsExp.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL ls_unexpected: ls_done_o with data %h, expected no access completion", ls_rdata_o);
            end else begin
               le = lsExp.pop_front();
               if (le[32]) checkOutput("ls_rdata", ls_rdata_o, le[31:0]);
            end
         end
      end
   end

   task automatic preload(input bit [31:0] a, input bit [7:0] d);
      ram[a] = d;
      shadow[a] = d;
   endtask

   // Issues one request at the current time (just after a rising edge) and holds it
   // until its done is accepted; expLat < 0 skips the grant-to-done latency check.
   task automatic applyStimulus(input bit isFetch, input bit we, input int len,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input bit checkAddr, input int expLat);
      logic [31:0] e = 32'h0;
      int n = 0;
      int nb;
      bit seen = 1'b0;
      bit done;
      string tag;
      nb = isFetch ? 4 : len;
      if (isFetch) tag = "fetch";
      else if (we) tag = "store";
      else tag = "load";
      for (int k = 0; k < nb; k++) begin
         if (!isFetch && we) shadow[addr + 32'(k)] = wdata[8*k +: 8];
         else e[8*k +: 8] = shadowRead(addr + 32'(k));
      end
      if (isFetch) ifExp.push_back(e);
      else lsExp.push_back({!we, e});
      if (isFetch) begin
         if_addr_i = addr;
         if_req_i  = 1'b1;
      end else begin
         ls_we_i    = we;
         ls_len_i   = 3'(len);
         ls_addr_i  = addr;
         ls_wdata_i = wdata;
         ls_req_i   = 1'b1;
      end
      while (!seen && n < TIMEOUT) begin
         @(negedge clk);
         done = isFetch ? if_done_o : ls_done_o;
         if (checkAddr && n >= 1 && n <= nb) begin
            checkOutput({tag, "_ram_a"}, ram_a_o, addr + 32'(n - 1));
            if (!isFetch && we) begin
               checkOutput("store_ram_wr", 32'(ram_wr_o), 32'd1);
               checkOutput("store_ram_dout", 32'(ram_dout_o), 32'(wdata[8*(n-1) +: 8]));
            end else begin
               checkOutput({tag, "_ram_wr"}, 32'(ram_wr_o), 32'd0);
            end
         end
         if (done && rdy) begin
            seen = 1'b1;
            if (expLat >= 0) checkOutput({tag, "_latency"}, 32'(n), 32'(expLat));
         end else begin
            n++;
         end
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s_timeout: no done after %0d cycles, expected done", tag, TIMEOUT);
      end
      @(posedge clk);
      #1;
      if (isFetch) if_req_i = 1'b0;
      else ls_req_i = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stim
      int doneCnt;
      int s0;
      int bad;
      bit stopRdy;

      preload(32'h100, 8'h13);
      preload(32'h101, 8'h05);
      preload(32'h102, 8'h00);
      preload(32'h103, 8'h00);
      preload(32'h80, 8'hF0);
      preload(32'h81, 8'hA5);

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_if_done", 32'(if_done_o), 32'd0);
      checkOutput("rst_ls_done", 32'(ls_done_o), 32'd0);
      checkOutput("rst_ram_wr", 32'(ram_wr_o), 32'd0);
      checkOutput("rst_ram_a", ram_a_o, 32'd0);
      checkOutput("rst_ram_dout", 32'(ram_dout_o), 32'd0);
      checkOutput("rst_if_data", if_data_o, 32'd0);
      checkOutput("rst_ls_rdata", ls_rdata_o, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] word fetch at 0x100");
      applyStimulus(1'b1, 1'b0, 4, 32'h100, 32'h0, 1'b1, 6);

      $display("[TB] simultaneous load and fetch");
      fork
         applyStimulus(1'b0, 1'b0, 4, 32'h200, 32'h0, 1'b1, 6);
         applyStimulus(1'b1, 1'b0, 4, 32'h100, 32'h0, 1'b0, 13);
      join

      $display("[TB] narrow loads and wrapping load");
      applyStimulus(1'b0, 1'b0, 1, 32'h80, 32'h0, 1'b1, 3);
      applyStimulus(1'b0, 1'b0, 2, 32'h80, 32'h0, 1'b1, 4);
      applyStimulus(1'b0, 1'b0, 4, 32'hFFFF_FFFE, 32'h0, 1'b1, 6);

      $display("[TB] word store at 0x200 then readback");
      applyStimulus(1'b0, 1'b1, 4, 32'h200, 32'hDEADBEEF, 1'b1, 5);
      applyStimulus(1'b0, 1'b0, 4, 32'h200, 32'h0, 1'b1, 6);
      applyStimulus(1'b0, 1'b1, 2, 32'h204, 32'h1234CAFE, 1'b1, 3);
      applyStimulus(1'b0, 1'b0, 4, 32'h203, 32'h0, 1'b0, 6);

      $display("[TB] flushed fetch");
      if_addr_i = 32'h300;
      if_req_i  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      clr_i    = 1'b1;
      if_req_i = 1'b0;
      @(posedge clk);
      #1;
      clr_i = 1'b0;
      doneCnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (if_done_o) doneCnt++;
      end
      checkOutput("flush_if_done_count", 32'(doneCnt), 32'd0);
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 1'b0, 4, 32'h104, 32'h0, 1'b1, 6);

      $display("[TB] flush during store");
      fork
         applyStimulus(1'b0, 1'b1, 4, 32'h2200, 32'h01234567, 1'b1, 5);
         begin
            repeat (2) @(posedge clk);
            #1;
            clr_i = 1'b1;
            @(posedge clk);
            #1;
            clr_i = 1'b0;
         end
      join

      $display("[TB] store paused after second byte");
      s0 = strobes;
      fork
         applyStimulus(1'b0, 1'b1, 4, 32'h2100, 32'hA1B2C3D4, 1'b0, 8);
         begin
            repeat (3) @(posedge clk);
            #1;
            rdy = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            rdy = 1'b1;
         end
      join
      checkOutput("pause_strobe_count", 32'(strobes - s0), 32'd4);
      checkOutput("pause_wr_while_paused", 32'(wrWhilePaused), 32'd0);

      $display("[TB] randomized traffic with random pauses");
      stopRdy = 1'b0;
      fork
         begin
            fork
               for (int i = 0; i < 30; i++) begin
                  repeat ($urandom_range(0, 3)) begin
                     @(posedge clk);
                     #1;
                  end
                  applyStimulus(1'b1, 1'b0, 4, 32'h1000 + $urandom_range(0, 255), 32'h0, 1'b0, -1);
               end
               for (int j = 0; j < 40; j++) begin
                  int l;
                  int pick;
                  pick = $urandom_range(0, 2);
                  l = (pick == 0) ? 1 : ((pick == 1) ? 2 : 4);
                  repeat ($urandom_range(0, 3)) begin
                     @(posedge clk);
                     #1;
                  end
                  applyStimulus(1'b0, 1'($urandom_range(0, 1)), l, 32'h2000 + $urandom_range(0, 255),
                                $urandom, 1'b0, -1);
               end
            join
            stopRdy = 1'b1;
         end
         begin
            while (!stopRdy) begin
               @(posedge clk);
               #1;
               rdy = ($urandom_range(0, 3) != 0);
            end
            rdy = 1'b1;
         end
      join

      repeat (5) @(posedge clk);
      bad = 0;
      foreach (shadow[a]) if (ramRead(a) != shadowRead(a)) bad++;
      foreach (ram[a]) if (ramRead(a) != shadowRead(a)) bad++;
      checkOutput("ram_image_bad_bytes", 32'(bad), 32'd0);
      checkOutput("if_queue_left", 32'(ifExp.size()), 32'd0);
      checkOutput("ls_queue_left", 32'(lsExp.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
